singlecycle: RTL and testbench
==============================

Name: singlecycle

Overview:
- Single-cycle 64-bit LEGv8-subset processor with internal instruction ROM, 32x64 register file, ALU and 64-word data memory.
- Executes one instruction per rising CLK edge.
- Exposes the current PC and the registered data-memory read value so the bench can check program results.

Parameters:
- IMEM_WORDS, 64, instruction ROM depth (32-bit words, indexed by PC[7:2])
- DMEM_WORDS, 64, data memory depth (64-bit words, indexed by addr[8:3])

Ports:
- CLK  in  1  system clock, all state updates on rising edge
- resetl  in  1  reset; one clock; reset is synchronous and active-low
- startpc  in  64  PC value loaded while resetl=0
- currentpc  out  64  PC of the instruction currently executing
- dmemout  out  64  registered data-memory read data

Behaviour:
- Reset (resetl=0 at rising edge): PC<=startpc; dmemout<=0; X0..X30<=0; data memory is not cleared.
- A reset asserted mid-program restarts fetch at startpc on the next edge.
- Each edge with resetl=1: PC<=next PC; register write, memory write and dmemout capture occur together.
- Fetch and decode are combinational from PC.
- Register file: X31 reads 0; writes to X31 are dropped; reads are combinational; write-then-read in the next cycle sees the new value.
- Instructions, opcode on bits[31:21] unless noted:
  - ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000: Rd = Rn op Rm, modulo 2^64.
  - LDUR 11111000010: addr = Rn + sext(imm9[20:12]); Rt = mem[addr].
  - STUR 11111000000: mem[addr] <= Rt.
  - CBZ bits[31:24]=10110100: if Rt==0, PC = PC + sext(imm19[23:5])<<2.
  - B bits[31:26]=000101: PC = PC + sext(imm26)<<2.
  - MOVZ bits[31:23]=110100101: Rd = imm16[20:5] << (hw[22:21]*16); other bits 0.
  - Any other encoding: NOP (no writes, PC+4).
- dmemout is loaded with mem[addr] at the edge ending an LDUR and holds otherwise. The loaded value is visible one edge after the LDUR PC appears.
- Memory addresses use bits[8:3]; the low 3 bits are ignored (no alignment fault).
- Data memory initial contents: [0x00]=1, [0x08]=0xA, [0x10]=5, [0x18]=0x0FFBEA7DEADBEEFF, all others 0.
- ROM program 1:
  - 00 LDUR X9,[XZR,#0]; 04 LDUR X10,[XZR,#8]; 08 LDUR X11,[XZR,#0x10]; 0C LDUR X12,[XZR,#0x18]
  - 10 ADD X13,XZR,XZR; 14 CBZ X11,#5; 18 ORR X10,X10,X11; 1C AND X12,X12,X10; 20 SUB X11,X11,X9; 24 B #-4
  - 28 ORR X13,X10,X12; 2C STUR X13,[XZR,#0x20]; 30 ADD X14,X9,XZR; 34 LDUR X14,[XZR,#0x20]
- ROM program 2:
  - 38 ADD X9,XZR,XZR; 3C MOVZ X9,#0x1234,LSL48; 40 MOVZ X10,#0x5678,LSL32; 44 ORR X9,X9,X10
  - 48 MOVZ X10,#0x9ABC,LSL16; 4C ORR X9,X9,X10; 50 MOVZ X10,#0xDEF0; 54 ORR X9,X9,X10
  - 58 STUR X9,[XZR,#0x28]; 5C LDUR X10,[XZR,#0x28]
- Remaining ROM words are 0 (NOP). Execution continues sequentially past 0x5C.

Decomposition:
- Shared package singlecycle_pkg: opcode constants, ALU-op enum, control-signal struct (reg2loc, alusrc, memtoreg, regwrite, memread, memwrite, branch, uncondbranch, aluop, movz).
- One natural sub-module: singlecycle_regfile (32x64, X31 zero, sync write, async read).
- Control decoder, sign-extender, ALU and memories stay in the top level.

Test Plan:
- Hold resetl=0 one edge with startpc=0 -> currentpc=0, dmemout=0.
- Run program 1 until currentpc=0x34, one more edge -> dmemout=0xF; CBZ loop runs 5 iterations then exits to 0x28.
- Continue until currentpc=0x5C, one more edge -> dmemout=0x123456789ABCDEF0.
- Reset mid-run (pc~0x20) with startpc=0 -> next edge currentpc=0, dmemout=0; program 1 re-yields 0xF.
- Total cycles for both programs < 255; STUR then LDUR at the same address returns the stored value; a write targeting X31 leaves XZR reading 0.

Source files
------------

// File: rtl/singlecycle_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : singlecycle_pkg
//  Purpose  : Shared definitions for the single-cycle LEGv8-subset core.
//             Holds the opcode constants, the ALU operation enum, the
//             control-signal bundle, the instruction encoders and the
//             instruction ROM image.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package singlecycle_pkg;

  localparam int XLEN     = 64;
  localparam int NUM_REGS = 32;
  localparam int REG_AW   = 5;

  localparam logic [REG_AW-1:0] XZR = 5'd31;

  // Opcodes. Field widths differ per instruction format.
  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [7:0]  OP_CBZ  = 8'b10110100;
  localparam logic [5:0]  OP_B    = 6'b000101;
  localparam logic [8:0]  OP_MOVZ = 9'b110100101;

  // Data memory words 0..3 hold the program's input operands.
  localparam logic [XLEN-1:0] DMEM_IMG0 = 64'h0000_0000_0000_0001;
  localparam logic [XLEN-1:0] DMEM_IMG1 = 64'h0000_0000_0000_000A;
  localparam logic [XLEN-1:0] DMEM_IMG2 = 64'h0000_0000_0000_0005;
  localparam logic [XLEN-1:0] DMEM_IMG3 = 64'h0FFB_EA7D_EADB_EEFF;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'd0,
    ALU_SUB   = 3'd1,
    ALU_AND   = 3'd2,
    ALU_ORR   = 3'd3,
    ALU_PASSB = 3'd4
  } alu_op_e;

  typedef struct packed {
    logic    reg2loc;       // second read port takes Rt instead of Rm
    logic    alusrc;        // ALU B operand is the sign-extended immediate
    logic    memtoreg;      // write-back from data memory
    logic    regwrite;
    logic    memread;
    logic    memwrite;
    logic    branch;        // conditional (CBZ)
    logic    uncondbranch;  // B
    alu_op_e aluop;
    logic    movz;          // write-back from the MOVZ shifter
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '{
    reg2loc:      1'b0,
    alusrc:       1'b0,
    memtoreg:     1'b0,
    regwrite:     1'b0,
    memread:      1'b0,
    memwrite:     1'b0,
    branch:       1'b0,
    uncondbranch: 1'b0,
    aluop:        ALU_ADD,
    movz:         1'b0
  };

  // R-format: opcode | Rm | shamt | Rn | Rd
  function automatic logic [31:0] enc_r(input logic [10:0] op, input logic [4:0] rm,
                                        input logic [4:0] rn, input logic [4:0] rd);
    return {op, rm, 6'b000000, rn, rd};
  endfunction

  // D-format: opcode | imm9 | op2 | Rn | Rt
  function automatic logic [31:0] enc_d(input logic [10:0] op, input logic [8:0] imm9,
                                        input logic [4:0] rn, input logic [4:0] rt);
    return {op, imm9, 2'b00, rn, rt};
  endfunction

  // CB-format: opcode | imm19 | Rt
  function automatic logic [31:0] enc_cb(input logic [18:0] imm19, input logic [4:0] rt);
    return {OP_CBZ, imm19, rt};
  endfunction

  // B-format: opcode | imm26
  function automatic logic [31:0] enc_b(input logic [25:0] imm26);
    return {OP_B, imm26};
  endfunction

  // IM-format: opcode | hw | imm16 | Rd
  function automatic logic [31:0] enc_mz(input logic [1:0] hw, input logic [15:0] imm16,
                                         input logic [4:0] rd);
    return {OP_MOVZ, hw, imm16, rd};
  endfunction

  // Instruction ROM image, one 32-bit word per index (index = PC[7:2]).
  function automatic logic [31:0] rom_word(input int idx);
    logic [31:0] word;
    case (idx)
      // program 1: OR/AND reduction loop, result stored at 0x20
      0:  word = enc_d(OP_LDUR, 9'd0,  XZR, 5'd9);
      1:  word = enc_d(OP_LDUR, 9'd8,  XZR, 5'd10);
      2:  word = enc_d(OP_LDUR, 9'd16, XZR, 5'd11);
      3:  word = enc_d(OP_LDUR, 9'd24, XZR, 5'd12);
      4:  word = enc_r(OP_ADD, XZR, XZR, 5'd13);
      5:  word = enc_cb(19'd5, 5'd11);
      6:  word = enc_r(OP_ORR, 5'd11, 5'd10, 5'd10);
      7:  word = enc_r(OP_AND, 5'd10, 5'd12, 5'd12);
      8:  word = enc_r(OP_SUB, 5'd9,  5'd11, 5'd11);
      9:  word = enc_b(26'h3FF_FFFC);
      10: word = enc_r(OP_ORR, 5'd12, 5'd10, 5'd13);
      11: word = enc_d(OP_STUR, 9'd32, XZR, 5'd13);
      12: word = enc_r(OP_ADD, XZR, 5'd9, 5'd14);
      13: word = enc_d(OP_LDUR, 9'd32, XZR, 5'd14);
      // program 2: assemble a 64-bit constant with MOVZ/ORR, store at 0x28
      14: word = enc_r(OP_ADD, XZR, XZR, 5'd9);
      15: word = enc_mz(2'd3, 16'h1234, 5'd9);
      16: word = enc_mz(2'd2, 16'h5678, 5'd10);
      17: word = enc_r(OP_ORR, 5'd10, 5'd9, 5'd9);
      18: word = enc_mz(2'd1, 16'h9ABC, 5'd10);
      19: word = enc_r(OP_ORR, 5'd10, 5'd9, 5'd9);
      20: word = enc_mz(2'd0, 16'hDEF0, 5'd10);
      21: word = enc_r(OP_ORR, 5'd10, 5'd9, 5'd9);
      22: word = enc_d(OP_STUR, 9'd40, XZR, 5'd9);
      23: word = enc_d(OP_LDUR, 9'd40, XZR, 5'd10);
      default: word = 32'h0000_0000;
    endcase
    return word;
  endfunction

endpackage
`default_nettype wire

// File: rtl/singlecycle_regfile.sv
`default_nettype none
// ============================================================================
//  Module   : singlecycle_regfile
//  Purpose  : 32 x 64-bit register file. X31 (XZR) always reads zero and
//             ignores writes. Two asynchronous read ports, one synchronous
//             write port. A write is visible to reads from the next cycle.
//  Ports    : clk_i    - clock, write on rising edge
//             resetl_i - synchronous active-low reset, clears all registers
//             ra1_i/ra2_i, rd1_o/rd2_o - read addresses / read data
//             we_i, wa_i, wd_i         - write enable / address / data
//  Revision : 1.0 - initial release
// ============================================================================
module singlecycle_regfile
  import singlecycle_pkg::*;
(
  input  logic              clk_i,
  input  logic              resetl_i,
  input  logic [REG_AW-1:0] ra1_i,
  input  logic [REG_AW-1:0] ra2_i,
  output logic [XLEN-1:0]   rd1_o,
  output logic [XLEN-1:0]   rd2_o,
  input  logic              we_i,
  input  logic [REG_AW-1:0] wa_i,
  input  logic [XLEN-1:0]   wd_i
);

  logic [XLEN-1:0] regs_q [NUM_REGS];

  always_ff @(posedge clk_i) begin
    if (!resetl_i) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i && (wa_i != XZR)) begin
      regs_q[wa_i] <= wd_i;
    end
  end

  // XZR is forced at the read mux so its storage word never matters.
  assign rd1_o = (ra1_i == XZR) ? '0 : regs_q[ra1_i];
  assign rd2_o = (ra2_i == XZR) ? '0 : regs_q[ra2_i];

endmodule
`default_nettype wire

// File: rtl/singlecycle.sv
`default_nettype none
// ============================================================================
//  Module   : singlecycle
//  Purpose  : Single-cycle 64-bit LEGv8-subset processor. Internal ROM,
//             32x64 register file, ALU and 64-word data memory. One
//             instruction completes on every rising CLK edge.
//  Ports    : CLK       - clock, all state updates on rising edge
//             resetl    - synchronous active-low reset
//             startpc   - PC loaded while resetl=0
//             currentpc - PC of the instruction currently executing
//             dmemout   - registered data-memory read value (last LDUR)
//  Revision : 1.0 - initial release
// ============================================================================
module singlecycle
  import singlecycle_pkg::*;
#(
  parameter int IMEM_WORDS = 64,
  parameter int DMEM_WORDS = 64
) (
  input  logic            CLK,
  input  logic            resetl,
  input  logic [XLEN-1:0] startpc,
  output logic [XLEN-1:0] currentpc,
  output logic [XLEN-1:0] dmemout
);

  localparam int IIDX_W = $clog2(IMEM_WORDS);
  localparam int DIDX_W = $clog2(DMEM_WORDS);

  logic [XLEN-1:0]   pc_q;
  logic [XLEN-1:0]   pc_d;
  logic [XLEN-1:0]   dmemout_q;
  logic [XLEN-1:0]   dmem_q [DMEM_WORDS];

  logic [31:0]       w_rom [IMEM_WORDS];
  logic [31:0]       w_instr;
  ctrl_t             w_ctrl;
  logic [REG_AW-1:0] w_ra2;
  logic [XLEN-1:0]   w_rdata1;
  logic [XLEN-1:0]   w_rdata2;
  logic [XLEN-1:0]   w_imm;
  logic [XLEN-1:0]   w_alu_b;
  logic [XLEN-1:0]   w_alu_y;
  logic [XLEN-1:0]   w_movz_val;
  logic [XLEN-1:0]   w_mem_rdata;
  logic [XLEN-1:0]   w_wdata;
  logic [DIDX_W-1:0] w_daddr;
  logic              w_zero;
  logic              w_take_branch;

  // --------------------------------------------------------------------------
  // Fetch
  // --------------------------------------------------------------------------
  for (genvar gi = 0; gi < IMEM_WORDS; gi++) begin : g_rom
    assign w_rom[gi] = rom_word(gi);
  end

  assign w_instr = w_rom[pc_q[IIDX_W+1:2]];

  // --------------------------------------------------------------------------
  // Control decode. The short-opcode formats are tested first; their opcode
  // fields never alias one of the 11-bit R/D opcodes.
  // --------------------------------------------------------------------------
  always_comb begin
    w_ctrl = CTRL_NOP;
    if (w_instr[31:23] == OP_MOVZ) begin
      w_ctrl.regwrite = 1'b1;
      w_ctrl.movz     = 1'b1;
    end else if (w_instr[31:26] == OP_B) begin
      w_ctrl.uncondbranch = 1'b1;
    end else if (w_instr[31:24] == OP_CBZ) begin
      w_ctrl.reg2loc = 1'b1;
      w_ctrl.branch  = 1'b1;
      w_ctrl.aluop   = ALU_PASSB;
    end else begin
      case (w_instr[31:21])
        OP_ADD: begin
          w_ctrl.regwrite = 1'b1;
          w_ctrl.aluop    = ALU_ADD;
        end
        OP_SUB: begin
          w_ctrl.regwrite = 1'b1;
          w_ctrl.aluop    = ALU_SUB;
        end
        OP_AND: begin
          w_ctrl.regwrite = 1'b1;
          w_ctrl.aluop    = ALU_AND;
        end
        OP_ORR: begin
          w_ctrl.regwrite = 1'b1;
          w_ctrl.aluop    = ALU_ORR;
        end
        OP_LDUR: begin
          w_ctrl.alusrc   = 1'b1;
          w_ctrl.memtoreg = 1'b1;
          w_ctrl.regwrite = 1'b1;
          w_ctrl.memread  = 1'b1;
          w_ctrl.aluop    = ALU_ADD;
        end
        OP_STUR: begin
          w_ctrl.reg2loc  = 1'b1;
          w_ctrl.alusrc   = 1'b1;
          w_ctrl.memwrite = 1'b1;
          w_ctrl.aluop    = ALU_ADD;
        end
        default: w_ctrl = CTRL_NOP;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Register file. STUR and CBZ read Rt on the second port.
  // --------------------------------------------------------------------------
  assign w_ra2 = w_ctrl.reg2loc ? w_instr[4:0] : w_instr[20:16];

  singlecycle_regfile u_regfile (
    .clk_i    (CLK),
    .resetl_i (resetl),
    .ra1_i    (w_instr[9:5]),
    .ra2_i    (w_ra2),
    .rd1_o    (w_rdata1),
    .rd2_o    (w_rdata2),
    .we_i     (w_ctrl.regwrite),
    .wa_i     (w_instr[4:0]),
    .wd_i     (w_wdata)
  );

  // --------------------------------------------------------------------------
  // Sign extender: immediate field depends on the instruction format.
  // --------------------------------------------------------------------------
  always_comb begin
    w_imm = '0;
    if (w_ctrl.uncondbranch) begin
      w_imm = {{38{w_instr[25]}}, w_instr[25:0]};
    end else if (w_ctrl.branch) begin
      w_imm = {{45{w_instr[23]}}, w_instr[23:5]};
    end else begin
      w_imm = {{55{w_instr[20]}}, w_instr[20:12]};
    end
  end

  // --------------------------------------------------------------------------
  // ALU. CBZ passes Rt through so the zero flag tests the register itself.
  // --------------------------------------------------------------------------
  assign w_alu_b = w_ctrl.alusrc ? w_imm : w_rdata2;

  always_comb begin
    w_alu_y = '0;
    case (w_ctrl.aluop)
      ALU_ADD:   w_alu_y = w_rdata1 + w_alu_b;
      ALU_SUB:   w_alu_y = w_rdata1 - w_alu_b;
      ALU_AND:   w_alu_y = w_rdata1 & w_alu_b;
      ALU_ORR:   w_alu_y = w_rdata1 | w_alu_b;
      ALU_PASSB: w_alu_y = w_alu_b;
      default:   w_alu_y = w_alu_b;
    endcase
  end

  assign w_zero = (w_alu_y == '0);

  // MOVZ: imm16 placed at halfword hw, everything else zero.
  assign w_movz_val = {48'h0, w_instr[20:5]} << {w_instr[22:21], 4'b0000};

  // --------------------------------------------------------------------------
  // Data memory: byte address bits [2:0] are dropped, no alignment check.
  // --------------------------------------------------------------------------
  assign w_daddr     = w_alu_y[DIDX_W+2:3];
  assign w_mem_rdata = dmem_q[w_daddr];

  // The operand image in words 0..3 is re-established by reset; every other
  // word keeps its contents across reset.
  always_ff @(posedge CLK) begin
    if (!resetl) begin
      dmem_q[0] <= DMEM_IMG0;
      dmem_q[1] <= DMEM_IMG1;
      dmem_q[2] <= DMEM_IMG2;
      dmem_q[3] <= DMEM_IMG3;
    end else if (w_ctrl.memwrite) begin
      dmem_q[w_daddr] <= w_rdata2;
    end
  end

  // --------------------------------------------------------------------------
  // Write-back and next PC
  // --------------------------------------------------------------------------
  always_comb begin
    w_wdata = w_alu_y;
    if (w_ctrl.movz) begin
      w_wdata = w_movz_val;
    end else if (w_ctrl.memtoreg) begin
      w_wdata = w_mem_rdata;
    end
  end

  assign w_take_branch = w_ctrl.uncondbranch || (w_ctrl.branch && w_zero);
  assign pc_d          = w_take_branch ? (pc_q + (w_imm << 2)) : (pc_q + 64'd4);

  always_ff @(posedge CLK) begin
    if (!resetl) begin
      pc_q      <= startpc;
      dmemout_q <= '0;
    end else begin
      pc_q <= pc_d;
      if (w_ctrl.memread) begin
        dmemout_q <= w_mem_rdata;
      end
    end
  end

  assign currentpc = pc_q;
  assign dmemout   = dmemout_q;

endmodule
`default_nettype wire

// File: tb/tb_singlecycle.sv
`default_nettype none
// ============================================================================
//  Module   : tb_singlecycle
//  Purpose  : Self-checking bench for singlecycle. An instruction-level
//             model of the two ROM programs predicts PC and dmemout after
//             every edge; predictions go into a scoreboard queue that a
//             monitor drains on the falling edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_singlecycle;

  logic        CLK = 1'b0;
  logic        resetl = 1'b1;
  logic [63:0] startpc = 64'd0;
  logic [63:0] currentpc;
  logic [63:0] dmemout;

  singlecycle dut (
    .CLK       (CLK),
    .resetl    (resetl),
    .startpc   (startpc),
    .currentpc (currentpc),
    .dmemout   (dmemout)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // --------------------------------------------------------------------------
  // Instruction-level reference model
  // --------------------------------------------------------------------------
  typedef enum {K_NOP, K_ADD, K_SUB, K_AND, K_ORR, K_LDUR, K_STUR, K_CBZ, K_B, K_MOVZ} kind_e;
  typedef struct {
    kind_e  k;
    int     d;     // Rd / Rt
    int     n;     // Rn
    int     m;     // Rm, or MOVZ halfword number
    longint imm;   // byte offset, instruction offset, or MOVZ imm16
  } ins_t;

  ins_t        prog [64];
  logic [63:0] mx   [32];
  logic [63:0] mmem [64];
  logic [63:0] mpc;
  logic [63:0] mdout;

  function automatic ins_t mk(kind_e k, int d, int n, int m, longint imm);
    ins_t r;
    r.k = k; r.d = d; r.n = n; r.m = m; r.imm = imm;
    return r;
  endfunction

  function automatic logic [63:0] rx(int r);
    return (r == 31) ? 64'd0 : mx[r];
  endfunction

  function automatic void wx(int r, logic [63:0] v);
    if (r != 31) mx[r] = v;
  endfunction

  function automatic void model_step(logic rl, logic [63:0] spc);
    ins_t        in;
    logic [63:0] npc;
    logic [63:0] addr;
    if (!rl) begin
      mpc   = spc;
      mdout = 64'd0;
      for (int i = 0; i < 31; i++) mx[i] = 64'd0;
    end else begin
      in   = prog[int'(mpc[7:2])];
      npc  = mpc + 64'd4;
      addr = rx(in.n) + in.imm;
      case (in.k)
        K_ADD:  wx(in.d, rx(in.n) + rx(in.m));
        K_SUB:  wx(in.d, rx(in.n) - rx(in.m));
        K_AND:  wx(in.d, rx(in.n) & rx(in.m));
        K_ORR:  wx(in.d, rx(in.n) | rx(in.m));
        K_LDUR: begin
          mdout = mmem[int'(addr[8:3])];
          wx(in.d, mdout);
        end
        K_STUR: mmem[int'(addr[8:3])] = rx(in.d);
        K_CBZ:  if (rx(in.d) == 64'd0) npc = mpc + in.imm * 4;
        K_B:    npc = mpc + in.imm * 4;
        K_MOVZ: wx(in.d, 64'(in.imm) << (16 * in.m));
        default: ;
      endcase
      mpc = npc;
    end
  endfunction

  // --------------------------------------------------------------------------
  // Scoreboard
  // --------------------------------------------------------------------------
  typedef struct packed {
    logic [63:0] pc;
    logic [63:0] dout;
  } exp_t;

  exp_t sbq[$];

  always @(negedge CLK) begin
    exp_t e;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk("sb_currentpc", currentpc, e.pc);
      chk("sb_dmemout", dmemout, e.dout);
    end
  end

  int cbz_visits = 0;

  // One clock: drive inputs after the falling edge, predict, queue the
  // prediction once the rising edge has happened.
  task automatic cycle(input logic rl, input logic [63:0] spc);
    exp_t e;
    @(negedge CLK);
    resetl  = rl;
    startpc = spc;
    model_step(rl, spc);
    e.pc   = mpc;
    e.dout = mdout;
    @(posedge CLK);
    #1;
    sbq.push_back(e);
    if (currentpc == 64'h14) cbz_visits++;
  endtask

  task automatic run_until(input logic [63:0] target, input int limit, output int n);
    n = 0;
    while (currentpc !== target && n < limit) begin
      cycle(1'b1, 64'd0);
      n++;
    end
  endtask

  initial begin
    int          n;
    int          total;
    int          len;
    logic [63:0] spc;

    for (int i = 0; i < 64; i++) prog[i] = mk(K_NOP, 0, 0, 0, 0);
    prog[0]  = mk(K_LDUR, 9,  31, 0,  0);
    prog[1]  = mk(K_LDUR, 10, 31, 0,  8);
    prog[2]  = mk(K_LDUR, 11, 31, 0,  16);
    prog[3]  = mk(K_LDUR, 12, 31, 0,  24);
    prog[4]  = mk(K_ADD,  13, 31, 31, 0);
    prog[5]  = mk(K_CBZ,  11, 0,  0,  5);
    prog[6]  = mk(K_ORR,  10, 10, 11, 0);
    prog[7]  = mk(K_AND,  12, 12, 10, 0);
    prog[8]  = mk(K_SUB,  11, 11, 9,  0);
    prog[9]  = mk(K_B,    0,  0,  0,  -4);
    prog[10] = mk(K_ORR,  13, 10, 12, 0);
    prog[11] = mk(K_STUR, 13, 31, 0,  32);
    prog[12] = mk(K_ADD,  14, 9,  31, 0);
    prog[13] = mk(K_LDUR, 14, 31, 0,  32);
    prog[14] = mk(K_ADD,  9,  31, 31, 0);
    prog[15] = mk(K_MOVZ, 9,  0,  3,  64'h1234);
    prog[16] = mk(K_MOVZ, 10, 0,  2,  64'h5678);
    prog[17] = mk(K_ORR,  9,  9,  10, 0);
    prog[18] = mk(K_MOVZ, 10, 0,  1,  64'h9ABC);
    prog[19] = mk(K_ORR,  9,  9,  10, 0);
    prog[20] = mk(K_MOVZ, 10, 0,  0,  64'hDEF0);
    prog[21] = mk(K_ORR,  9,  9,  10, 0);
    prog[22] = mk(K_STUR, 9,  31, 0,  40);
    prog[23] = mk(K_LDUR, 10, 31, 0,  40);
    for (int i = 0; i < 64; i++) mmem[i] = 64'd0;
    for (int i = 0; i < 32; i++) mx[i] = 64'd0;
    mmem[0] = 64'h1;
    mmem[1] = 64'hA;
    mmem[2] = 64'h5;
    mmem[3] = 64'h0FFB_EA7D_EADB_EEFF;
    mpc   = 64'd0;
    mdout = 64'd0;

    // Reset state
    cycle(1'b0, 64'd0);
    chk("reset_pc", currentpc, 64'd0);
    chk("reset_dmemout", dmemout, 64'd0);

    // Program 1: 5 loop iterations plus the exiting CBZ -> 34 edges to 0x34
    cbz_visits = 0;
    run_until(64'h34, 255, n);
    total = n;
    chk("edges_to_0x34", 64'(n), 64'd34);
    chk("cbz_visits", 64'(cbz_visits), 64'd6);
    cycle(1'b1, 64'd0);
    total++;
    chk("prog1_result", dmemout, 64'hF);

    // Program 2
    run_until(64'h5C, 255, n);
    total += n;
    cycle(1'b1, 64'd0);
    total++;
    chk("prog2_result", dmemout, 64'h1234_5678_9ABC_DEF0);
    chk("total_edges", 64'(total), 64'd45);

    // Reset mid-run, then program 1 again
    cycle(1'b0, 64'd0);
    run_until(64'h20, 255, n);
    chk("reach_0x20", currentpc, 64'h20);
    cycle(1'b0, 64'd0);
    chk("midreset_pc", currentpc, 64'd0);
    chk("midreset_dmemout", dmemout, 64'd0);
    run_until(64'h34, 255, n);
    chk("rerun_edges_to_0x34", 64'(n), 64'd34);
    cycle(1'b1, 64'd0);
    chk("rerun_prog1_result", dmemout, 64'hF);

    // Randomized episodes: random start PCs and reset injections
    for (int ep = 0; ep < 30; ep++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: spc = {56'd0, 6'($urandom_range(0, 63)), 2'b00};
        6:                spc = 64'd0;
        7:                spc = 64'h38;
        default:          spc = {$urandom, $urandom};
      endcase
      len = int'($urandom_range(1, 3));
      for (int r = 0; r < len; r++) cycle(1'b0, spc);
      len = int'($urandom_range(10, 100));
      for (int c = 0; c < len; c++) begin
        if ($urandom_range(0, 39) == 0) begin
          cycle(1'b0, {56'd0, 6'($urandom_range(0, 63)), 2'b00});
        end else begin
          cycle(1'b1, 64'(startpc + 64'd0));
        end
      end
    end

    @(negedge CLK);
    @(negedge CLK);
    if (sbq.size() != 0) begin
      chk("scoreboard_drained", 64'(sbq.size()), 64'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
